// File: rtl/sram_port_arbiter_if.sv
// Purpose: bundles the mode, both requester ports and the SRAM side of the arbiter.
// Latency: none; this file only carries wires.
// Backpressure: requesters hold req until the combinational gnt is seen.
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  test_mode;
  logic                  test_active;

  logic                  f_req;
  logic                  f_we;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [DATA_WIDTH-1:0] f_wdata;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic                  csb0;
  logic                  web0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;

  // Arbiter side.
  modport slave (
    input  test_mode,
    input  f_req, f_we, f_addr, f_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  dout0,
    output test_active,
    output f_gnt, f_rvalid, f_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output csb0, web0, addr0, din0
  );

  // Requester / SRAM side.
  modport master (
    output test_mode,
    output f_req, f_we, f_addr, f_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output dout0,
    input  test_active,
    input  f_gnt, f_rvalid, f_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  csb0, web0, addr0, din0
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose: shares one single-port SRAM between a functional and a BIST requester, with mode drain.
// Latency: command registered 1 cycle after transfer; read data + rvalid 3 cycles after transfer.
// Backpressure: combinational grant; no grant in drain states or the cycle a mode switch is seen.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    MISSION = 2'd0,
    DRAIN_T = 2'd1,
    TEST    = 2'd2,
    DRAIN_M = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_b;     // 1 = BIST owned the most recent transfer
  logic s1_vld;     // read on the SRAM command bus this cycle
  logic s1_b;
  logic s2_vld;     // read whose data is on dout0 this cycle
  logic s2_b;
  logic rd_busy;
  logic f_gnt_c;
  logic b_gnt_c;
  logic f_xfer;
  logic b_xfer;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign rd_busy = s1_vld | s2_vld;

  // Next state and grants; a mode change seen in MISSION/TEST blocks grants that cycle.
  always_comb begin
    state_nxt = state;
    f_gnt_c   = 1'b0;
    b_gnt_c   = 1'b0;
    case (state)
      MISSION: begin
        if (bus.test_mode) begin
          state_nxt = DRAIN_T;
        end else begin
          f_gnt_c = bus.f_req & (~bus.b_req | last_b);
          b_gnt_c = bus.b_req & ~(bus.f_req & (~bus.b_req | last_b));
        end
      end
      DRAIN_T: if (!rd_busy) state_nxt = TEST;
      TEST: begin
        if (!bus.test_mode) state_nxt = DRAIN_M;
        else                b_gnt_c   = bus.b_req;
      end
      DRAIN_M: if (!rd_busy) state_nxt = MISSION;
      default: state_nxt = MISSION;
    endcase
    if (rst) begin
      f_gnt_c = 1'b0;
      b_gnt_c = 1'b0;
    end
  end

  assign bus.f_gnt = f_gnt_c;
  assign bus.b_gnt = b_gnt_c;
  assign f_xfer    = bus.f_req & f_gnt_c;
  assign b_xfer    = bus.b_req & b_gnt_c;

  // Select the attributes of whichever requester transfers this cycle.
  always_comb begin
    sel_we    = bus.b_we;
    sel_addr  = bus.b_addr;
    sel_wdata = bus.b_wdata;
    if (f_xfer) begin
      sel_we    = bus.f_we;
      sel_addr  = bus.f_addr;
      sel_wdata = bus.f_wdata;
    end
  end

  // State, last owner and the registered mode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= MISSION;
      last_b          <= 1'b1;
      bus.test_active <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.test_active <= (state_nxt == TEST);
      if (f_xfer)      last_b <= 1'b0;
      else if (b_xfer) last_b <= 1'b1;
    end
  end

  // Registered SRAM command; addr0/din0 keep their value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.csb0  <= 1'b1;
      bus.web0  <= 1'b1;
      bus.addr0 <= '0;
      bus.din0  <= '0;
    end else if (f_xfer | b_xfer) begin
      bus.csb0  <= 1'b0;
      bus.web0  <= ~sel_we;
      bus.addr0 <= sel_addr;
      bus.din0  <= sel_wdata;
    end else begin
      bus.csb0  <= 1'b1;
      bus.web0  <= 1'b1;
    end
  end

  // Two-stage read tag pipeline; the owner travels with each read so returns never misroute.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_b   <= 1'b0;
      s2_vld <= 1'b0;
      s2_b   <= 1'b0;
    end else begin
      s1_vld <= (f_xfer | b_xfer) & ~sel_we;
      s1_b   <= b_xfer;
      s2_vld <= s1_vld;
      s2_b   <= s1_b;
    end
  end

  // Capture dout0 while the read sits in stage 2 and pulse the owner's rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.f_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.f_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      bus.f_rvalid <= s2_vld & ~s2_b;
      bus.b_rvalid <= s2_vld & s2_b;
      if (s2_vld & ~s2_b) bus.f_rdata <= bus.dout0;
      if (s2_vld & s2_b)  bus.b_rdata <= bus.dout0;
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 9, SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, SRAM data width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed first as follows:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have the following mode ports:
- test_mode  in  1  1 = BIST owns the SRAM (driven by the test wrapper).
- test_active  out  1  1 = TEST state reached.
REQ-005 The block SHALL have the following functional-requester ports:
- f_req  in  1  request; held until granted.
- f_we  in  1  1 = write, 0 = read.
- f_addr  in  ADDR_WIDTH  word address.
- f_wdata  in  DATA_WIDTH  write data.
- f_gnt  out  1  combinational grant.
- f_rvalid  out  1  one-cycle read-data strobe.
- f_rdata  out  DATA_WIDTH  read data.
REQ-006 The block SHALL have the following BIST-requester ports:
- b_req  in  1  request; held until granted.
- b_we  in  1  1 = write, 0 = read.
- b_addr  in  ADDR_WIDTH  word address.
- b_wdata  in  DATA_WIDTH  write data.
- b_gnt  out  1  combinational grant.
- b_rvalid  out  1  one-cycle read-data strobe.
- b_rdata  out  DATA_WIDTH  read data.
REQ-007 The block SHALL have the following SRAM-side ports:
- csb0  out  1  chip select, active low.
- web0  out  1  write enable, active low.
- addr0  out  ADDR_WIDTH  SRAM address.
- din0  out  DATA_WIDTH  SRAM write data.
- dout0  in  DATA_WIDTH  SRAM read data.

Function
REQ-008 The handshake SHALL be: a transfer occurs on the rising edge ending a cycle in which x_req=1 and x_gnt=1; attributes are sampled at that edge.
REQ-009 f_gnt and b_gnt SHALL never both be 1.
REQ-010 f_gnt and b_gnt SHALL be 0 while rst=1 and in every DRAIN state.
REQ-011 The FSM SHALL have states MISSION, DRAIN_T, TEST and DRAIN_M.
REQ-012 In MISSION, grants SHALL follow the single requester if only one requests.
REQ-013 In MISSION, when both request, the grant SHALL go to the requester not granted at the most recent transfer (round-robin).
REQ-014 The last-owner register SHALL update on every transfer.
REQ-015 In TEST, b_gnt SHALL equal b_req, f_gnt SHALL be 0, and f_req SHALL be ignored (no error, no queuing).
REQ-016 MISSION SHALL transition to DRAIN_T when test_mode=1.
REQ-017 TEST SHALL transition to DRAIN_M when test_mode=0.
REQ-018 A test_mode change SHALL take effect at the next edge; no grant SHALL be issued in the cycle the FSM leaves MISSION or TEST.
REQ-019 DRAIN_T SHALL transition to TEST, and DRAIN_M to MISSION, when no read is in pipeline stage 1 or stage 2.
REQ-020 If test_mode reverts during a DRAIN state, the FSM SHALL still complete to the drain target, then follow REQ-016/REQ-017.
REQ-021 test_active SHALL be 1 only in TEST; it is registered.
REQ-022 The SRAM command SHALL be registered: a transfer at edge E0 drives csb0=0, web0=~we, addr0=addr, din0=wdata during cycle C1.
REQ-023 In any cycle without a transfer, csb0=1 and web0=1 SHALL apply, and addr0/din0 SHALL hold their last values.
REQ-024 For a read, the block SHALL rely on dout0 being valid in C2, capture it at edge E2, and present it on the owner's rdata with a one-cycle rvalid pulse in C3 (latency 3 cycles from the transfer cycle).
REQ-025 The owner tag SHALL travel with the read through both stages; rvalid SHALL go only to the issuing requester.
REQ-026 rdata SHALL hold its value until the next read return for that requester.
REQ-027 Back-to-back transfers, one per cycle, SHALL be supported; read returns are in issue order.
REQ-028 Writes SHALL produce no rvalid.
REQ-029 A mode switch SHALL never drop or misroute an in-flight read; a read issued in MISSION returns to its owner even after TEST is entered.

Reset
REQ-030 While rst=1 at an edge, the block SHALL set: state=MISSION; last-owner=BIST (functional wins the first tie).
REQ-031 While rst=1 at an edge, the block SHALL set csb0=1, web0=1, addr0=0, din0=0.
REQ-032 While rst=1 at an edge, the block SHALL set f_rvalid=0, b_rvalid=0, f_rdata=0, b_rdata=0, and test_active=0.
REQ-033 While rst=1 at an edge, the block SHALL clear the pipeline tags.
REQ-034 Reset mid-operation SHALL discard in-flight reads: no rvalid in any cycle after the reset edge.

Verification
REQ-035 The bench SHALL cover: after reset, f_req=1, f_we=1, f_addr=5, f_wdata=0xA5A5A5A5 -> f_gnt=1 in that cycle; next cycle csb0=0, web0=0, addr0=5, din0=0xA5A5A5A5; following idle cycle csb0=1.
REQ-036 The bench SHALL cover: f_req and b_req held high for 6 cycles in MISSION -> grants F,B,F,B,F,B; csb0=0 in 6 consecutive cycles.
REQ-037 The bench SHALL cover: functional read addr 7 at C0, SRAM model drives dout0=0x12345678 in C2 -> f_rvalid=1, f_rdata=0x12345678 in C3; b_rvalid=0 throughout.
REQ-038 The bench SHALL cover: test_mode=1 in the cycle after a functional read transfer -> no grant until the read retires from stage 2; test_active=1 afterwards; f_rvalid still pulses; f_req then never granted.
REQ-039 The bench SHALL cover: TEST with b_req held, test_mode=0 -> DRAIN_M then MISSION; test_active falls; next tie with f_req grants per last-owner.
REQ-040 The bench SHALL cover: rst=1 in C1 of a BIST read -> next cycle csb0=1, gnts=0, and no b_rvalid in any later cycle.
